// File: rtl/kws_pad_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : kws_pad_buffer_if
// Description : Stream bundle around the KWS pad buffer.
//               Input side carries ReLU words (data, channel address, strobe;
//               no backpressure).
//               Output side is a ready/valid stream of padded frames.
//               The slave modport is the pad buffer's view.
//               The master modport is the surrounding datapath's view: it
//               feeds ReLU words and consumes the padded stream.
// Signals     : in_data   ReLU output word
//               in_addr   ReLU channel address
//               in_valid  input word strobe
//               out_data  padded stream word
//               out_addr  channel index of out_data
//               out_valid output word valid
//               out_ready downstream accept
//               out_last  final word of the utterance
// Revision    : 1.0 - initial release
// ============================================================================
interface kws_pad_buffer_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] in_data;
  logic [4:0]        in_addr;
  logic              in_valid;

  logic [DATA_W-1:0] out_data;
  logic [4:0]        out_addr;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport slave (
    input  in_data,
    input  in_addr,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_addr,
    output out_valid,
    output out_last
  );

  modport master (
    output in_data,
    output in_addr,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_addr,
    input  out_valid,
    input  out_last
  );

endinterface
`default_nettype wire

// File: rtl/kws_pad_buffer.sv
`default_nettype none
// ============================================================================
// Module      : kws_pad_buffer
// Description : Temporal zero-padding and frame buffer between the ReLU stage
//               and the CNN/systolic stage of the KWS datapath.
//               ReLU words are captured into a word FIFO.
//               The output stream carries, in order:
//                 - PAD_L all-zero frames;
//                 - every buffered real frame;
//                 - PAD_R all-zero frames once flush has been seen and the
//                   buffer has drained.
// Ports       : wb_clk_i   clock
//               wb_rst_i   synchronous active-high reset
//               start      pulse: begin (or restart) an utterance
//               flush      pulse: no more input frames
//               bus        stream bundle (slave view): in_* capture side,
//                          out_* ready/valid side
//               busy       high in any state except IDLE
//               done       one-cycle completion pulse
//               overflow   sticky: an input word was dropped (FIFO full)
//               seq_err    sticky: in_addr did not follow 0..CH-1
//               frame_cnt  real frames emitted, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module kws_pad_buffer #(
  parameter int DATA_W     = 32,
  parameter int CH         = 20,
  parameter int PAD_L      = 2,
  parameter int PAD_R      = 2,
  parameter int FIFO_DEPTH = 64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             flush,
  kws_pad_buffer_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             seq_err,
  output logic [7:0]       frame_cnt
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int             c_aw         = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]  c_depth      = (c_aw+1)'(FIFO_DEPTH);
  localparam logic [c_aw:0]  c_ptr_one    = (c_aw+1)'(1);
  localparam logic [4:0]     c_last_ch    = 5'(CH - 1);
  localparam logic [9:0]     c_head_words = 10'(PAD_L * CH);
  localparam logic [9:0]     c_tail_words = 10'(PAD_R * CH);
  localparam logic [9:0]     c_tail_final = 10'(PAD_R * CH - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PAD_HEAD = 3'd1,
    S_STREAM   = 3'd2,
    S_PAD_TAIL = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_aw:0]       r_wr_ptr;
  logic [c_aw:0]       r_rd_ptr;

  logic [4:0]          r_in_ch;      // expected address of the next input word
  logic [4:0]          r_out_ch;     // channel of the word in the output register
  logic [9:0]          r_pad_cnt;    // pad words loaded in the current pad phase
  logic                r_flush;

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;
  logic                r_out_pad;    // output register holds a pad word

  logic                r_overflow;
  logic                r_seq_err;
  logic [7:0]          r_frame_cnt;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [c_aw:0]       w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_in_phase;
  logic                w_capture;
  logic                w_push;
  logic                w_load;
  logic                w_accept;
  logic                w_pop;
  logic                w_head_issue;
  logic                w_tail_issue;
  logic                w_stream_end;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  // Full is judged on the registered pointers, before any pop in the same
  // cycle, so a write while full is always dropped.
  assign w_full     = (w_count == c_depth);
  assign w_empty    = (w_count == '0);

  assign w_in_phase = (r_state == S_PAD_HEAD) || (r_state == S_STREAM);
  assign w_capture  = bus.in_valid && w_in_phase && !start;
  assign w_push     = w_capture && !w_full && !wb_rst_i;

  assign w_load     = !r_out_valid || bus.out_ready;
  assign w_accept   = r_out_valid && bus.out_ready;

  assign w_pop        = w_load && (r_state == S_STREAM) && !w_empty && !start;
  assign w_head_issue = w_load && (r_state == S_PAD_HEAD) && (r_pad_cnt != c_head_words);
  assign w_tail_issue = w_load && (r_state == S_PAD_TAIL) && (r_pad_cnt != c_tail_words);

  // Tail padding may only begin on a frame boundary with nothing left in
  // flight; an incomplete last frame keeps the block in STREAM.
  assign w_stream_end = r_flush && w_empty && !r_out_valid && (r_out_ch == '0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);

    if (start) begin
      // Start from any state behaves as a fresh start from IDLE.
      w_state_nxt = (PAD_L > 0) ? S_PAD_HEAD : S_STREAM;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_PAD_HEAD: begin
          // All head words loaded and the one in the register just left.
          if (w_accept && (r_pad_cnt == c_head_words)) begin
            w_state_nxt = S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_stream_end) begin
            w_state_nxt = S_PAD_TAIL;
          end
        end
        S_PAD_TAIL: begin
          if (w_accept && (r_pad_cnt == c_tail_words)) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage (no reset needed; validity is tracked by the pointers)
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= bus.in_data;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: capture, output register, counters and sticky flags.
  // A start clears exactly what a reset clears, except the FSM state.
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || start) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_in_ch     <= '0;
      r_out_ch    <= '0;
      r_pad_cnt   <= '0;
      r_flush     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_pad   <= 1'b0;
      r_overflow  <= 1'b0;
      r_seq_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (flush && w_in_phase) begin
        r_flush <= 1'b1;
      end

      // Input capture. The channel counter advances on every honoured word,
      // dropped ones included, so one overflow does not misalign later frames.
      if (w_capture) begin
        r_in_ch <= (r_in_ch == c_last_ch) ? 5'd0 : r_in_ch + 5'd1;
        if (bus.in_addr != r_in_ch) begin
          r_seq_err <= 1'b1;
        end
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end

      // Beat accepted: advance the output channel and count real frames.
      if (w_accept) begin
        r_out_ch <= (r_out_ch == c_last_ch) ? 5'd0 : r_out_ch + 5'd1;
        if (!r_out_pad && (r_out_ch == c_last_ch) && (r_frame_cnt != 8'hFF)) begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
      end

      // Output register refill; an empty refill clears the stage.
      if (w_load) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_last  <= 1'b0;
        r_out_pad   <= 1'b0;
        if (w_pop) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_mem[r_rd_ptr[c_aw-1:0]];
        end else if (w_head_issue) begin
          r_out_valid <= 1'b1;
          r_out_pad   <= 1'b1;
          r_pad_cnt   <= r_pad_cnt + 10'd1;
        end else if (w_tail_issue) begin
          r_out_valid <= 1'b1;
          r_out_pad   <= 1'b1;
          r_out_last  <= (r_pad_cnt == c_tail_final);
          r_pad_cnt   <= r_pad_cnt + 10'd1;
        end
      end

      // Each pad phase counts from zero.
      if (w_state_nxt != r_state) begin
        r_pad_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_ch;
  assign bus.out_last  = r_out_last;
  assign overflow      = r_overflow;
  assign seq_err       = r_seq_err;
  assign frame_cnt     = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_kws_pad_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_kws_pad_buffer
// Description : Self-checking bench for kws_pad_buffer (CH=20, PAD_L=2,
//               PAD_R=2, FIFO_DEPTH=64). Expected beats are queued as stimulus
//               is driven and compared as the DUT hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kws_pad_buffer;

  localparam int DATA_W = 32;
  localparam int CH     = 20;
  localparam int PADW   = 2 * CH;   // words in a head or tail pad

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        start;
  logic        flush;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        seq_err;
  logic [7:0]  frame_cnt;

  kws_pad_buffer_if #(.DATA_W(DATA_W)) bus_if ();

  kws_pad_buffer #(
    .DATA_W     (DATA_W),
    .CH         (CH),
    .PAD_L      (2),
    .PAD_R      (2),
    .FIFO_DEPTH (64)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .start     (start),
    .flush     (flush),
    .bus       (bus_if.slave),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .seq_err   (seq_err),
    .frame_cnt (frame_cnt)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  // --------------------------------------------------------------------------
  // Counters, scoreboard
  // --------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        last;
  } beat_t;

  beat_t q[$];
  bit    mon_en   = 1'b0;
  int    done_cnt = 0;
  int    beat_cnt = 0;
  int    rdy_mode = 0;   // 0: always ready, 1: alternate, 2: never ready

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready pattern
  initial begin
    bus_if.out_ready = 1'b0;
    forever begin
      @(posedge wb_clk_i);
      #1;
      case (rdy_mode)
        0:       bus_if.out_ready = 1'b1;
        1:       bus_if.out_ready = ~bus_if.out_ready;
        default: bus_if.out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: sampled on the falling edge, a beat seen valid&&ready
  // here is the one accepted on the next rising edge.
  initial begin
    logic        prev_stall;
    logic [38:0] prev_word;
    beat_t       e;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        prev_stall = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (prev_stall) begin
          chk("stall_hold", {25'd0, bus_if.out_valid, bus_if.out_last, bus_if.out_addr, bus_if.out_data},
              {25'd0, prev_word});
        end
        prev_stall = bus_if.out_valid && !bus_if.out_ready && !start;
        prev_word  = {bus_if.out_valid, bus_if.out_last, bus_if.out_addr, bus_if.out_data};
        if (mon_en && bus_if.out_valid && bus_if.out_ready) begin
          beat_cnt++;
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat %0d: got data %0h addr %0d, required no beat",
                     beat_cnt, bus_if.out_data, bus_if.out_addr);
          end else begin
            e = q.pop_front();
            chk($sformatf("beat_%0d{last,addr,data}", beat_cnt),
                {26'd0, bus_if.out_last, bus_if.out_addr, bus_if.out_data},
                {26'd0, e.last, e.addr, e.data});
          end
        end
      end
    end
  end

  // Global safety net
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic idle();
    @(posedge wb_clk_i);
    #1;
    bus_if.in_valid = 1'b0;
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [4:0] a);
    @(posedge wb_clk_i);
    #1;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    bus_if.in_addr  = a;
  endtask

  task automatic pulse_start();
    @(posedge wb_clk_i);
    #1;
    bus_if.in_valid = 1'b0;
    start = 1'b1;
    @(posedge wb_clk_i);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge wb_clk_i);
    #1;
    bus_if.in_valid = 1'b0;
    flush = 1'b1;
    @(posedge wb_clk_i);
    #1;
    flush = 1'b0;
  endtask

  task automatic push_pad(input bit tail);
    beat_t b;
    for (int i = 0; i < PADW; i++) begin
      b.data = '0;
      b.addr = 5'(i % CH);
      b.last = tail && (i == PADW - 1);
      q.push_back(b);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic [4:0] a);
    beat_t b;
    b.data = d;
    b.addr = a;
    b.last = 1'b0;
    q.push_back(b);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge wb_clk_i);
      k++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    @(negedge wb_clk_i);
    while (!done && k < budget) begin
      @(negedge wb_clk_i);
      k++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    @(negedge wb_clk_i);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    repeat (4) @(negedge wb_clk_i);
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("queue_empty", 64'(q.size()), 64'd0);
  endtask

  // --------------------------------------------------------------------------
  // Scenario table: full utterances with different frame counts and ready
  // patterns; expected beat count = head pad + frames*CH + tail pad.
  // --------------------------------------------------------------------------
  typedef struct {
    int         nframes;
    int         rmode;
    logic [7:0] exp_fc;
    int         exp_beats;
  } scen_t;

  scen_t scen [3];

  initial begin
    scen[0] = '{nframes: 3, rmode: 0, exp_fc: 8'd3, exp_beats: 140};
    scen[1] = '{nframes: 3, rmode: 1, exp_fc: 8'd3, exp_beats: 140};
    scen[2] = '{nframes: 1, rmode: 0, exp_fc: 8'd1, exp_beats: 100};

    wb_rst_i        = 1'b1;
    start           = 1'b0;
    flush           = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    bus_if.in_addr  = '0;

    // ---- power-on reset state
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    chk("rst_out_last",  {63'd0, bus_if.out_last},  64'd0);
    chk("rst_busy",      {63'd0, busy},             64'd0);
    chk("rst_done",      {63'd0, done},             64'd0);
    chk("rst_frame_cnt", {56'd0, frame_cnt},        64'd0);
    #1 wb_rst_i = 1'b0;

    // ---- reset asserted mid-STREAM
    rdy_mode = 0;
    pulse_start();
    for (int c = 0; c < CH; c++) send_word(32'(c + 1), 5'(c));
    idle();
    repeat (60) idle();
    send_word(32'hABCD, 5'd7);          // out-of-sequence word
    rdy_mode = 2;
    for (int i = 1; i < 10; i++) send_word(32'(300 + i), 5'(i));
    idle();
    repeat (3) idle();
    chk("pre_rst_frame_cnt", {56'd0, frame_cnt}, 64'd1);
    chk("pre_rst_seq_err",   {63'd0, seq_err},   64'd1);
    chk("pre_rst_valid",     {63'd0, bus_if.out_valid}, 64'd1);
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    @(posedge wb_clk_i);
    #1;
    chk("mid_rst_{valid,last,addr,data}",
        {26'd0, bus_if.out_valid, bus_if.out_last, bus_if.out_addr, bus_if.out_data}, 64'd0);
    chk("mid_rst_{busy,done,ovf,seq}", {60'd0, busy, done, overflow, seq_err}, 64'd0);
    chk("mid_rst_frame_cnt", {56'd0, frame_cnt}, 64'd0);
    wb_rst_i = 1'b0;
    q.delete();
    mon_en = 1'b1;

    // ---- table-driven utterances (the first also proves start after reset)
    for (int s = 0; s < 3; s++) begin
      done_cnt = 0;
      beat_cnt = 0;
      rdy_mode = scen[s].rmode;
      push_pad(1'b0);
      pulse_start();
      for (int f = 0; f < scen[s].nframes; f++) begin
        for (int c = 0; c < CH; c++) begin
          push_word(32'(f * 100 + c), 5'(c));
          send_word(32'(f * 100 + c), 5'(c));
        end
      end
      idle();
      push_pad(1'b1);
      pulse_flush();
      wait_done(3000);
      chk($sformatf("s%0d_beats", s), 64'(beat_cnt), 64'(scen[s].exp_beats));
      chk($sformatf("s%0d_frame_cnt", s), {56'd0, frame_cnt}, {56'd0, scen[s].exp_fc});
      chk($sformatf("s%0d_flags", s), {62'd0, overflow, seq_err}, 64'd0);
    end

    // ---- overflow: 70 words into a 64-word FIFO with the output stalled
    rdy_mode = 2;
    push_pad(1'b0);
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      push_word(32'(1000 + i), 5'(i % CH));
      send_word(32'(1000 + i), 5'(i % CH));
    end
    idle();
    chk("ovf_after_64", {63'd0, overflow}, 64'd0);
    send_word(32'd1064, 5'd4);
    idle();
    chk("ovf_after_65", {63'd0, overflow}, 64'd1);
    for (int i = 65; i < 70; i++) send_word(32'(1000 + i), 5'(i % CH));
    idle();
    rdy_mode = 0;
    wait_drain(1000);
    repeat (20) idle();
    chk("ovf_sticky", {63'd0, overflow}, 64'd1);

    // ---- sequence error: addresses 0..4,6..20; the next start clears overflow
    done_cnt = 0;
    push_pad(1'b0);
    pulse_start();
    chk("ovf_cleared_by_start", {63'd0, overflow}, 64'd0);
    for (int c = 0; c < CH; c++) begin
      push_word(32'(500 + c), 5'(c));
      send_word(32'(500 + c), (c < 5) ? 5'(c) : 5'(c + 1));
    end
    idle();
    chk("seq_err_set", {63'd0, seq_err}, 64'd1);
    push_pad(1'b1);
    pulse_flush();
    wait_done(1000);
    chk("seq_frame_cnt", {56'd0, frame_cnt}, 64'd1);
    chk("seq_err_sticky", {63'd0, seq_err}, 64'd1);

    // ---- restart in STREAM with 10 words buffered
    done_cnt = 0;
    push_pad(1'b0);
    pulse_start();
    chk("seq_err_cleared_by_start", {63'd0, seq_err}, 64'd0);
    for (int c = 0; c < CH; c++) begin
      push_word(32'(700 + c), 5'(c));
      send_word(32'(700 + c), 5'(c));
    end
    idle();
    wait_drain(500);
    rdy_mode = 2;
    for (int i = 0; i < 10; i++) send_word(32'(900 + i), 5'(i));
    idle();
    repeat (3) idle();
    chk("rs_frame_cnt_before", {56'd0, frame_cnt}, 64'd1);
    chk("rs_busy_before", {63'd0, busy}, 64'd1);
    push_pad(1'b0);
    pulse_start();
    rdy_mode = 0;
    chk("rs_frame_cnt_after", {56'd0, frame_cnt}, 64'd0);
    for (int c = 0; c < CH; c++) begin
      push_word(32'(800 + c), 5'(c));
      send_word(32'(800 + c), 5'(c));
    end
    idle();
    push_pad(1'b1);
    pulse_flush();
    wait_done(1000);
    chk("rs_frame_cnt_end", {56'd0, frame_cnt}, 64'd1);

    repeat (5) idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kws_pad_buffer.md
Name: kws_pad_buffer

Overview:
- Temporal zero-padding and frame buffer between the ReLU stage and the CNN/systolic stage of the KWS datapath.
- Accepts per-channel ReLU words (data, channel address, valid; no backpressure) into a word FIFO.
- Emits a ready/valid stream of frames: PAD_L all-zero frames, every buffered real frame in order, then PAD_R all-zero frames after flush.
- Started and flushed by the kws FSM (padding_en phase).

Parameters:
- DATA_W, 32, word width of ReLU output and CNN input.
- CH, 20, channels per frame (1..32); channel address width is 5.
- PAD_L, 2, leading zero frames (0..15).
- PAD_R, 2, trailing zero frames (1..15).
- FIFO_DEPTH, 64, word FIFO depth (power of 2, ≥ CH).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse: begin utterance.
- flush  in  1  one-cycle pulse: no more input frames.
- in_data  in  DATA_W  ReLU output word.
- in_addr  in  5  ReLU channel address.
- in_valid  in  1  input word strobe.
- out_data  out  DATA_W  padded stream word.
- out_addr  out  5  channel index of out_data.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  final word of utterance.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky: input word dropped.
- seq_err  out  1  sticky: in_addr out of sequence.
- frame_cnt  out  8  real frames emitted, saturating at 255.

Behaviour:
- Reset:
  - FSM goes to IDLE; FIFO is emptied.
  - All outputs are 0, including out_data, out_addr, out_valid, out_last, done, overflow, seq_err and frame_cnt.
- FSM states: IDLE, PAD_HEAD, STREAM, PAD_TAIL, DONE.
  - IDLE: on start, go to PAD_HEAD if PAD_L>0, else STREAM.
  - PAD_HEAD: emits PAD_L*CH words with data 0. Goes to STREAM after the last beat is accepted.
  - STREAM: forwards FIFO words. Goes to PAD_TAIL when all four hold: flush latched, FIFO empty, output register empty, output channel counter == 0.
  - PAD_TAIL: emits PAD_R*CH zero words. Goes to DONE after the last beat is accepted.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start in any non-IDLE state restarts the utterance: FIFO cleared, counters cleared, flush latch cleared, output register dropped, overflow and seq_err cleared, then the IDLE start transition is taken.
- flush is latched only in PAD_HEAD or STREAM; it is ignored elsewhere.
- Input capture:
  - in_valid is honoured in PAD_HEAD and STREAM only; elsewhere it is dropped silently.
  - The full flag is evaluated before any same-cycle pop. A write while full is dropped and sets overflow, even if a pop occurs in that cycle.
  - An input channel counter starts at 0 and wraps at CH-1 on each captured word.
  - in_addr != counter sets seq_err; the word is still stored and the counter still advances.
- Output register (single stage):
  - Loads when out_valid==0 or out_ready==1.
  - out_data, out_addr and out_last are held stable while out_valid && !out_ready.
  - A beat is accepted when out_valid && out_ready.
  - out_addr comes from an output channel counter (0..CH-1, wrapping); it advances per accepted beat.
- Latency: with an idle output register, a word captured at edge t is presented after edge t+1.
- frame_cnt increments when a real (non-pad) word with out_addr==CH-1 is accepted.
- out_last is 1 only on the final PAD_TAIL word (channel CH-1 of the last tail frame).
- busy drops in the cycle after DONE.

Test Plan:
- Reset (CH=20, PAD_L=2, PAD_R=2): wb_rst_i held 2 cycles mid-STREAM -> all outputs 0, busy=0, FIFO empty; a subsequent start works normally.
- Basic utterance: start; 3 frames with data=frame*100+ch and addr 0..19; flush; out_ready=1 ->
  - 40 zero words, then 60 words 0..19, 100..119, 200..219, then 40 zero words;
  - out_addr cycles 0..19 throughout;
  - out_last on word 140 only; done pulses once; frame_cnt=3.
- Backpressure: same stimulus with out_ready alternating 1,0 -> identical 140-word sequence, no drop or duplicate, out_data/out_addr stable during stalls.
- Overflow: out_ready=0, start, 70 input words -> 64 stored, overflow=1 from the 65th word; then out_ready=1 -> the 64 stored words appear after the head pad; next start clears overflow.
- Sequence error: a frame with in_addr 0..4, 6, ... -> seq_err=1; all words still emitted; seq_err clears on the next start.
- Mid-operation restart: start issued during STREAM with 10 words buffered -> buffered words discarded, a fresh 40-zero head pad is emitted, frame_cnt=0.
